// File: rtl/hist_eq_sequencer.sv
// Control sequencer for histogram equalization: optional scratch-memory clear,
// then histogram -> CDF -> divider stages. Clear phase enabled by HIST_EQ_SEQ_CLEAR_EN.
module hist_eq_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              histogram_done,
  input  logic              cdf_done,
  input  logic              divider_done,
  output logic              histogram_en,
  output logic              cdf_en,
  output logic              divider_en,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] clr_mem_waddr,
  output logic [DATA_W-1:0] clr_mem_wdata,
  output logic              clr_mem_WE
);

  typedef enum logic [2:0] {
    IDLE, HIST, CDF, DIV, DONE
`ifdef HIST_EQ_SEQ_CLEAR_EN
    , CLR
`endif
  } state_t;

  state_t state, state_nxt;
  logic   hist_nxt, cdf_nxt, div_nxt, busy_nxt, done_nxt, err_nxt, stray;

`ifdef HIST_EQ_SEQ_CLEAR_EN
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] clr_addr, clr_addr_nxt;
  logic              clr_we;
`endif

  // Next-state: abort outranks any simultaneous stage completion
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef HIST_EQ_SEQ_CLEAR_EN
          state_nxt = CLR;
`else
          state_nxt = HIST;
`endif
        end
      end
`ifdef HIST_EQ_SEQ_CLEAR_EN
      CLR: begin
        if (abort)                      state_nxt = IDLE;
        else if (clr_addr == ADDR_MAX)  state_nxt = HIST;
      end
`endif
      HIST: begin
        if (abort)               state_nxt = IDLE;
        else if (histogram_done) state_nxt = CDF;
      end
      CDF: begin
        if (abort)         state_nxt = IDLE;
        else if (cdf_done) state_nxt = DIV;
      end
      DIV: begin
        if (abort)             state_nxt = IDLE;
        else if (divider_done) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with the state
  always_comb begin
    stray    = (histogram_done && state != HIST) ||
               (cdf_done       && state != CDF)  ||
               (divider_done   && state != DIV);
    err_nxt  = ((state == IDLE && start) ? 1'b0 : err) | stray;
    hist_nxt = (state_nxt == HIST);
    cdf_nxt  = (state_nxt == CDF);
    div_nxt  = (state_nxt == DIV);
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      histogram_en <= 1'b0;
      cdf_en       <= 1'b0;
      divider_en   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_nxt;
      histogram_en <= hist_nxt;
      cdf_en       <= cdf_nxt;
      divider_en   <= div_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      err          <= err_nxt;
    end
  end

`ifdef HIST_EQ_SEQ_CLEAR_EN
  // Counter restarts at zero on every entry to CLR and on any exit from it
  always_comb begin
    clr_addr_nxt = '0;
    if (state == CLR && state_nxt == CLR) clr_addr_nxt = clr_addr + ADDR_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_addr <= '0;
      clr_we   <= 1'b0;
    end else begin
      clr_addr <= clr_addr_nxt;
      clr_we   <= (state_nxt == CLR);
    end
  end

  assign clr_mem_waddr = clr_addr;
  assign clr_mem_WE    = clr_we;
  assign clr_mem_wdata = '0;
`else
  assign clr_mem_waddr = '0;
  assign clr_mem_WE    = 1'b0;
  assign clr_mem_wdata = '0;
`endif

endmodule

// File: tb/tb_hist_eq_sequencer.sv
// Scoreboard bench for hist_eq_sequencer: randomized passes with abort, stray
// completions and mid-pass reset; expected traces derived from per-stage durations.
module tb_hist_eq_sequencer;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 20;
`ifdef HIST_EQ_SEQ_CLEAR_EN
  localparam int NCLR = 1 << ADDR_W;
`else
  localparam int NCLR = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n, start, abort, histogram_done, cdf_done, divider_done;
  logic              histogram_en, cdf_en, divider_en, busy, done, err, clr_mem_WE;
  logic [ADDR_W-1:0] clr_mem_waddr;
  logic [DATA_W-1:0] clr_mem_wdata;

  hist_eq_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .histogram_done(histogram_done), .cdf_done(cdf_done), .divider_done(divider_done),
    .histogram_en(histogram_en), .cdf_en(cdf_en), .divider_en(divider_en),
    .busy(busy), .done(done), .err(err),
    .clr_mem_waddr(clr_mem_waddr), .clr_mem_wdata(clr_mem_wdata), .clr_mem_WE(clr_mem_WE)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              h, c, d, busy, done, err, we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } obs_t;

  obs_t act;
  obs_t expq[$];
  int   checks = 0;
  int   errors = 0;
  logic exp_err = 1'b0;

  always_comb act = {histogram_en, cdf_en, divider_en, busy, done, err, clr_mem_WE,
                     clr_mem_waddr, clr_mem_wdata};

  // Monitor: one expected observation per clock edge that the stimulus scheduled
  always @(negedge clk) begin
    obs_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL outputs t=%0t actual=%h required=%h (h c d busy done err we addr data)",
                 $time, act, e);
      end
    end
  end

  task automatic step(input logic st, ab, hd, cd, dd, input logic accept, stray,
                      input int en, input logic bsy, dn, we, input int addr);
    obs_t e;
    start = st; abort = ab; histogram_done = hd; cdf_done = cd; divider_done = dd;
    if (accept) exp_err = 1'b0;
    if (stray)  exp_err = 1'b1;
    e.h = (en == 1); e.c = (en == 2); e.d = (en == 3);
    e.busy = bsy; e.done = dn; e.err = exp_err; e.we = we;
    e.addr = ADDR_W'(addr); e.data = '0;
    @(posedge clk);
    expq.push_back(e);
    #1;
  endtask

  // Idle cycle; optional noise: abort (must be ignored) and stray completions (set err)
  task automatic idle_cycle(input bit noise);
    logic ab, hd, cd, dd;
    ab = 0; hd = 0; cd = 0; dd = 0;
    if (noise) begin
      ab = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0: hd = 1;
          1: cd = 1;
          default: dd = 1;
        endcase
      end
    end
    step(0, ab, hd, cd, dd, 0, hd | cd | dd, 0, 0, 0, 0, 0);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (act !== '0) begin
      errors++;
      $display("FAIL %s actual=%h required=0", name, act);
    end
  endtask

  task automatic do_reset();
    start = 0; abort = 0; histogram_done = 0; cdf_done = 0; divider_done = 0;
    @(negedge clk); #1;
    rst_n = 0;
    exp_err = 1'b0;
    #1 check_zero("async_reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
  endtask

  // One pass: stage s keeps its enable for dur[s]+1 cycles; abort/reset cut it short
  task automatic run_pass(input int d0, d1, d2, input int ab_stage, ab_off,
                          input bit stray_hist, start_abort, rst_div, input int rst_off);
    int   dur[3];
    int   en;
    logic hd, cd, dd, st, stray;
    dur[0] = d0; dur[1] = d1; dur[2] = d2;
    step(1, start_abort, 0, 0, 0, 1, 0, (NCLR > 0) ? 0 : 1, 1, 0, (NCLR > 0), 0);
    if (NCLR > 0) begin
      for (int k = 1; k < NCLR; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, k);
      step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    end
    for (int s = 0; s < 3; s++) begin
      for (int j = 0; j <= dur[s]; j++) begin
        hd = (s == 0 && j == dur[s]);
        cd = (s == 1 && j == dur[s]);
        dd = (s == 2 && j == dur[s]);
        stray = 0;
        if (stray_hist && s == 0 && j == 0) begin dd = 1; stray = 1; end
        st = ($urandom_range(0, 3) == 0);
        if (rst_div && s == 2 && j == rst_off) begin
          do_reset();
          return;
        end
        if (ab_stage == s && ab_off == j) begin
          step(st, 1, hd, cd, dd, 0, stray, 0, 0, 0, 0, 0);
          return;
        end
        en = (j < dur[s]) ? s + 1 : ((s == 2) ? 0 : s + 2);
        step(st, 0, hd, cd, dd, 0, stray, en, 1, (s == 2 && j == dur[s]), 0, 0);
      end
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int d0, d1, d2, as, ao;
    rst_n = 1; start = 0; abort = 0; histogram_done = 0; cdf_done = 0; divider_done = 0;
    #2 rst_n = 0;
    #1 check_zero("power_on_reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    repeat (2) idle_cycle(0);

    run_pass(3, 3, 3, -1, 0, 0, 0, 0, 0);          // nominal, 4-cycle enables
    repeat (2) idle_cycle(0);
    run_pass(2, 3, 4, 1, 3, 0, 0, 0, 0);           // abort with cdf_done together
    repeat (3) idle_cycle(0);
    run_pass(2, 2, 2, -1, 0, 1, 0, 0, 0);          // stray divider_done in HIST
    repeat (3) idle_cycle(0);
    run_pass(1, 0, 2, -1, 0, 0, 1, 0, 0);          // start with abort in IDLE clears err
    repeat (2) idle_cycle(0);
    run_pass(1, 1, 5, -1, 0, 0, 0, 1, 2);          // reset during DIV
    repeat (3) idle_cycle(0);

    for (int n = 0; n < 24; n++) begin
      d0 = $urandom_range(0, 4); d1 = $urandom_range(0, 4); d2 = $urandom_range(0, 4);
      as = -1; ao = 0;
      if ($urandom_range(0, 2) == 0) begin
        as = $urandom_range(0, 2);
        ao = $urandom_range(0, (as == 0) ? d0 : (as == 1) ? d1 : d2);
      end
      run_pass(d0, d1, d2, as, ao, 1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 1)), 0, 0);
      repeat ($urandom_range(1, 4)) idle_cycle(1);
    end

    repeat (2) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
